// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// active-low hex decode table, blank pattern and the captured update record.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  // Segment order {g,f,e,d,c,b,a}, active-low (common-anode display).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX2SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Sized for the widest supported display; narrower builds leave the upper bits at zero.
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
  } upd_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side register interface of the display controller: update data with a
// load strobe, brightness, and the pending/frame_done status back to the CPU.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;
  logic [3:0]              brightness;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output value, dp, digit_en, lz_blank, load, brightness,
    input  pending, frame_done
  );

  modport slave (
    input  value, dp, digit_en, lz_blank, load, brightness,
    output pending, frame_done
  );
endinterface

// File: rtl/seg7_tick_gen.sv
// Slot prescaler: cnt runs 0..DIV-1 and tick marks the last cycle of each slot.
module seg7_tick_gen #(
  parameter int DIV = 100_000,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  assign tick = (cnt == CW'(DIV - 1));

  // NOTE: clocked state is updated with non-blocking assignments only, so every
  // always_ff reads the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous updates,
// leading-zero blanking and anode dead-time. Define SEG7_PWM_DIM_EN for the brightness dimmer.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  seg7_scan_ctrl_if.slave       bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp_out
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int CW   = $clog2(DIV);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int SLOT = DIV - DEAD_CYCLES;

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 2..8");
  end
  if (DIV < DEAD_CYCLES + 16) begin : g_bad_div
    $error("seg7_scan_ctrl: slot too short for the dead time");
  end

  logic [CW-1:0] cnt;
  logic          tick;

  seg7_tick_gen #(.DIV(DIV), .CW(CW)) u_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .cnt    (cnt),
    .tick   (tick)
  );

  logic [IW-1:0] idx;
  logic          boundary;
  upd_t          in_upd, pend_q, disp_q;
  logic          pending_q, frame_done_q;

  assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a value held and no latch is inferred.
  always_comb begin
    in_upd          = '0;
    in_upd.value    = (4*MAX_DIGITS)'(bus.value);
    in_upd.dp       = MAX_DIGITS'(bus.dp);
    in_upd.digit_en = MAX_DIGITS'(bus.digit_en);
    in_upd.lz_blank = bus.lz_blank;
  end

  // Updates land only on the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      idx          <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (tick) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      if (boundary) begin
        pending_q <= 1'b0;
        if (bus.load) begin
          disp_q <= in_upd;
        end else if (pending_q) begin
          disp_q <= pend_q;
        end
      end else if (bus.load) begin
        pend_q    <= in_upd;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

  logic unused_disp;
  assign unused_disp = ^{disp_q.value, disp_q.dp, disp_q.digit_en};

  // Leading zeros are blanked from the top digit down; digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  always_comb begin
    lz_mask  = '0;
    zero_run = disp_q.lz_blank;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (disp_q.value[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dp, cur_en, cur_lz;

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_q.value[4*i +: 4];
        cur_dp  = disp_q.dp[i];
        cur_en  = disp_q.digit_en[i];
        cur_lz  = lz_mask[i];
      end
    end
  end

  logic slot_on;

`ifdef SEG7_PWM_DIM_EN
  // Duty length is latched per slot so a brightness change never truncates a lit slot.
  logic [CW:0] on_len_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      on_len_q <= (CW+1)'(SLOT);
    end else if (tick) begin
      on_len_q <= (CW+1)'(((int'(bus.brightness) + 1) * SLOT) >> 4);
    end
  end

  assign slot_on = (cnt >= CW'(DEAD_CYCLES)) &&
                   (({1'b0, cnt} - (CW+1)'(DEAD_CYCLES)) < on_len_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign slot_on = (cnt >= CW'(DEAD_CYCLES));
`endif

  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (slot_on) begin
      an_d = ~(NUM_DIGITS'(1) << idx);
    end
    if (cur_en && !cur_lz) begin
      seg_d = HEX2SEG[cur_nib];
    end
    if (cur_en) begin
      dp_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      an     <= '1;
      seg    <= SEG_BLANK;
      dp_out <= 1'b1;
    end else begin
      an     <= an_d;
      seg    <= seg_d;
      dp_out <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: table of display updates checked over a full
// scan frame, plus reset, double-load, boundary-load and reset-with-pending sequences.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 20;
  localparam int SLOT  = 18;
  localparam int FRAME = N * DIV;
`ifdef SEG7_PWM_DIM_EN
  localparam bit DIM_EN = 1'b1;
`else
  localparam bit DIM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp_out;

  int checks = 0;
  int errors = 0;
  int fd_cnt;
  bit saw_one;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLK_HZ      (1000),
    .SCAN_HZ     (50),
    .DEAD_CYCLES (2)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .an     (an),
    .seg    (seg),
    .dp_out (dp_out)
  );

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic            lz;
    logic [3:0]      br;
    logic [3:0][6:0] seg_exp;  // per digit, [3] = leftmost
    logic [3:0]      dpo_exp;  // active-low dp per digit
  } vec_t;

  vec_t vecs [5];
  vec_t v1111, v2222, v5555, v8888, vzero;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_fd(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick_cycle();
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_done wait", 32'(seen), 32'd1);
  endtask

  function automatic int exp_on(input logic [3:0] br);
    int on;
    on = SLOT;
    if (DIM_EN) on = ((int'(br) + 1) * SLOT) >> 4;
    return on;
  endfunction

  task automatic load_vec(input vec_t v);
    bus.value      = v.value;
    bus.dp         = v.dp;
    bus.digit_en   = v.en;
    bus.lz_blank   = v.lz;
    bus.brightness = v.br;
    bus.load       = 1'b1;
    tick_cycle();
    bus.load       = 1'b0;
  endtask

  // Starts just after a boundary edge; samples one whole frame and ends on the next boundary.
  task automatic collect_frame(input vec_t v, input string tag);
    int on_cnt [4];
    int d;
    for (int k = 0; k < 4; k++) on_cnt[k] = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick_cycle();
      if (an !== 4'hF) begin
        d = -1;
        for (int k = 0; k < 4; k++) begin
          if (an === ~(4'b0001 << k)) d = k;
        end
        if (d < 0) begin
          checks++;
          errors++;
          $display("FAIL %s anode pattern: got %0h expected one low bit", tag, an);
        end else begin
          on_cnt[d]++;
          check($sformatf("%s d%0d seg", tag, d), 32'(seg), 32'(v.seg_exp[d]));
          check($sformatf("%s d%0d dp", tag, d), 32'(dp_out), 32'(v.dpo_exp[d]));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s d%0d lit cycles", tag, k), 32'(on_cnt[k]), 32'(exp_on(v.br)));
    end
    check({tag, " frame length"}, 32'(bus.frame_done), 32'd1);
  endtask

  task automatic watch_cycle();
    tick_cycle();
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (an !== 4'hF && seg === 7'h79) saw_one = 1'b1;
  endtask

  initial begin
    vecs[0] = '{value:16'h12AF, dp:4'b0100, en:4'hF, lz:1'b0, br:4'd15,
                seg_exp:{7'h79, 7'h24, 7'h08, 7'h0E}, dpo_exp:4'b1011};
    vecs[1] = '{value:16'h0050, dp:4'b0000, en:4'hF, lz:1'b1, br:4'd7,
                seg_exp:{7'h7F, 7'h7F, 7'h12, 7'h40}, dpo_exp:4'b1111};
    vecs[2] = '{value:16'h0000, dp:4'b1000, en:4'hF, lz:1'b1, br:4'd15,
                seg_exp:{7'h7F, 7'h7F, 7'h7F, 7'h40}, dpo_exp:4'b0111};
    vecs[3] = '{value:16'h8F30, dp:4'b0110, en:4'b1011, lz:1'b0, br:4'd3,
                seg_exp:{7'h00, 7'h7F, 7'h30, 7'h40}, dpo_exp:4'b1101};
    vecs[4] = '{value:16'h0A00, dp:4'b0000, en:4'hF, lz:1'b1, br:4'd0,
                seg_exp:{7'h7F, 7'h08, 7'h40, 7'h40}, dpo_exp:4'b1111};
    v1111 = '{value:16'h1111, dp:4'b0000, en:4'hF, lz:1'b0, br:4'd15,
              seg_exp:{7'h79, 7'h79, 7'h79, 7'h79}, dpo_exp:4'b1111};
    v2222 = '{value:16'h2222, dp:4'b0000, en:4'hF, lz:1'b0, br:4'd15,
              seg_exp:{7'h24, 7'h24, 7'h24, 7'h24}, dpo_exp:4'b1111};
    v5555 = '{value:16'h5555, dp:4'b0001, en:4'hF, lz:1'b0, br:4'd15,
              seg_exp:{7'h12, 7'h12, 7'h12, 7'h12}, dpo_exp:4'b1110};
    v8888 = '{value:16'h8888, dp:4'b1111, en:4'hF, lz:1'b0, br:4'd15,
              seg_exp:{7'h00, 7'h00, 7'h00, 7'h00}, dpo_exp:4'b0000};
    vzero = '{value:16'h0000, dp:4'b0000, en:4'h0, lz:1'b0, br:4'd15,
              seg_exp:{7'h7F, 7'h7F, 7'h7F, 7'h7F}, dpo_exp:4'b1111};

    rst_n          = 1'b0;
    bus.value      = '0;
    bus.dp         = '0;
    bus.digit_en   = '0;
    bus.lz_blank   = 1'b0;
    bus.load       = 1'b0;
    bus.brightness = 4'd15;

    repeat (3) tick_cycle();
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp_out", 32'(dp_out), 32'd1);
    check("reset pending", 32'(bus.pending), 32'd0);
    check("reset frame_done", 32'(bus.frame_done), 32'd0);

    rst_n = 1'b1;
    tick_cycle();
    tick_cycle();
    check("dead time after release", 32'(an), 32'hF);
    tick_cycle();
    check("first anode", 32'(an), 32'hE);

    wait_fd(2 * FRAME);
    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      check($sformatf("vec%0d pending set", i), 32'(bus.pending), 32'd1);
      wait_fd(2 * FRAME);
      check($sformatf("vec%0d pending cleared", i), 32'(bus.pending), 32'd0);
      collect_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Two loads inside one frame: the later one wins, one commit pulse.
    fd_cnt  = 0;
    saw_one = 1'b0;
    load_vec(v1111);
    if (bus.frame_done === 1'b1) fd_cnt++;
    repeat (10) watch_cycle();
    load_vec(v2222);
    check("double load pending", 32'(bus.pending), 32'd1);
    for (int i = 0; i < 2 * FRAME && fd_cnt == 0; i++) watch_cycle();
    check("double load frame_done count", 32'(fd_cnt), 32'd1);
    check("double load first value shown", 32'(saw_one), 32'd0);
    collect_frame(v2222, "double load");

    // Load asserted exactly on the boundary cycle commits directly.
    repeat (FRAME - 1) tick_cycle();
    load_vec(v5555);
    check("boundary load pending", 32'(bus.pending), 32'd0);
    check("boundary load frame_done", 32'(bus.frame_done), 32'd1);
    collect_frame(v5555, "boundary load");

    // Reset while an update is pending discards it.
    load_vec(v8888);
    check("pre-reset pending", 32'(bus.pending), 32'd1);
    repeat (5) tick_cycle();
    rst_n = 1'b0;
    tick_cycle();
    check("mid reset an", 32'(an), 32'hF);
    check("mid reset seg", 32'(seg), 32'h7F);
    check("mid reset dp_out", 32'(dp_out), 32'd1);
    check("mid reset pending", 32'(bus.pending), 32'd0);
    check("mid reset frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    wait_fd(2 * FRAME);
    check("post reset pending", 32'(bus.pending), 32'd0);
    collect_frame(vzero, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
